// File: rtl/gshare_pred_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Contents: FSM state enum, index-hash selectors, saturating counter step.
package gshare_pred_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned HASH_GSHARE = 0;
  localparam int unsigned HASH_GLOBAL = 1;

  // Widest counter supported; narrower counters are zero-extended into this.
  localparam int unsigned CNT_W_MAX = 4;

  // One saturating step of a cnt_w-bit counter; holds at 0 and at 2^cnt_w-1.
  function automatic logic [CNT_W_MAX-1:0] cnt_sat_next(
    input logic [CNT_W_MAX-1:0] cnt,
    input logic                 taken,
    input int unsigned          cnt_w
  );
    logic [CNT_W_MAX-1:0] ceil;
    ceil = CNT_W_MAX'((32'd1 << cnt_w) - 32'd1);
    if (taken) begin
      return (cnt == ceil) ? cnt : cnt + CNT_W_MAX'(1);
    end
    return (cnt == '0) ? cnt : cnt - CNT_W_MAX'(1);
  endfunction

endpackage

// File: rtl/pht_ram.sv
// Pattern history table: 2^IDX_W saturating counters.
// Ports:
//   clk          clock
//   rd_idx_i     lookup index        -> rd_cnt_o combinational counter value
//   init_en_i    init sweep write    (writes weakly-not-taken at init_idx_i)
//   upd_en_i     counter update      (saturating step of entry upd_idx_i)
//   upd_taken_i  update direction
// The single write port is shared; an init write wins over an update.
module pht_ram
  import gshare_pred_pkg::*;
#(
  parameter int unsigned IDX_W = 10,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o,
  input  logic             init_en_i,
  input  logic [IDX_W-1:0] init_idx_i,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int unsigned      DEPTH   = 1 << IDX_W;
  localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'((32'd1 << (CNT_W - 1)) - 32'd1);

  logic [CNT_W-1:0] mem_q [DEPTH];

  logic             wr_en_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic [CNT_W-1:0] wr_cnt_c;

  assign rd_cnt_o = mem_q[rd_idx_i];

  // Write-port mux between init sweep and read-modify-write update.
  always_comb begin
    wr_en_c  = init_en_i | upd_en_i;
    wr_idx_c = upd_idx_i;
    wr_cnt_c = CNT_W'(cnt_sat_next(CNT_W_MAX'(mem_q[upd_idx_i]), upd_taken_i, CNT_W));
    if (init_en_i) begin
      wr_idx_c = init_idx_i;
      wr_cnt_c = WEAK_NT;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_idx_c] <= wr_cnt_c;
    end
  end

endmodule

// File: rtl/gshare_pred_unit.sv
// Global-history (gshare / pure global) branch direction predictor.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ready                    PHT init sweep finished
//   pred_req/pred_br/pred_pc fetch lookup -> pred_taken (comb), pred_idx, pred_ghr
//   upd_valid/upd_idx/upd_taken/upd_mispred/upd_ghr  resolved-branch writeback
// Optional: define GSHARE_PRED_STATS_EN to add stat_lookups, stat_updates,
// stat_mispreds 32-bit event counters.
module gshare_pred_unit
  import gshare_pred_pkg::*;
#(
  parameter int unsigned GHR_W     = 8,
  parameter int unsigned PHT_IDX_W = 10,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned HASH_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 pred_req,
  input  logic                 pred_br,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  output logic [PHT_IDX_W-1:0] pred_idx,
  output logic [GHR_W-1:0]     pred_ghr,
  input  logic                 upd_valid,
  input  logic [PHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken,
  input  logic                 upd_mispred,
  input  logic [GHR_W-1:0]     upd_ghr
`ifdef GSHARE_PRED_STATS_EN
  ,
  output logic [31:0]          stat_lookups,
  output logic [31:0]          stat_updates,
  output logic [31:0]          stat_mispreds
`endif
);

  localparam logic [PHT_IDX_W-1:0] LAST_IDX = '1;

  state_e               state_q, state_d;
  logic [PHT_IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [GHR_W-1:0]     ghr_q, ghr_d;
  logic                 ready_q, ready_d;

  logic [PHT_IDX_W-1:0] lookup_idx;
  logic [PHT_IDX_W-1:0] ghr_ext;
  logic [CNT_W-1:0]     rd_cnt;
  logic                 init_en_c;
  logic                 upd_en_c;
  logic [GHR_W:0]       spec_w;
  logic [GHR_W:0]       repair_w;
  logic                 unused_bits;

  assign ghr_ext = PHT_IDX_W'(ghr_q);

  generate
    if (HASH_MODE == HASH_GLOBAL) begin : g_hash_global
      assign lookup_idx = ghr_ext;
    end else begin : g_hash_gshare
      assign lookup_idx = pred_pc[PHT_IDX_W+1:2] ^ ghr_ext;
    end
  endgenerate

  assign ready      = ready_q;
  assign pred_idx   = lookup_idx;
  assign pred_ghr   = ghr_q;
  assign pred_taken = ready_q & rd_cnt[CNT_W-1];

  // History shifted by one bit; the concatenation form also covers GHR_W == 1.
  assign spec_w   = {ghr_q, pred_taken};
  assign repair_w = {upd_ghr, upd_taken};

  assign unused_bits = ^{pred_pc, spec_w[GHR_W], repair_w[GHR_W]};

  pht_ram #(
    .IDX_W (PHT_IDX_W),
    .CNT_W (CNT_W)
  ) u_pht (
    .clk         (clk),
    .rd_idx_i    (lookup_idx),
    .rd_cnt_o    (rd_cnt),
    .init_en_i   (init_en_c & ~rst),
    .init_idx_i  (init_ptr_q),
    .upd_en_i    (upd_en_c & ~rst),
    .upd_idx_i   (upd_idx),
    .upd_taken_i (upd_taken)
  );

  // Next-state: init sweep, then prediction/update with mispredict repair.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    ready_d    = ready_q;
    init_en_c  = 1'b0;
    upd_en_c   = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_en_c  = 1'b1;
        init_ptr_d = init_ptr_q + PHT_IDX_W'(1);
        if (init_ptr_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        upd_en_c = upd_valid;
        // Repair wins: a same-cycle fetch is on the wrong path.
        if (upd_valid && upd_mispred) begin
          ghr_d = repair_w[GHR_W-1:0];
        end else if (pred_req && pred_br) begin
          ghr_d = spec_w[GHR_W-1:0];
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
      ready_q    <= ready_d;
    end
  end

`ifdef GSHARE_PRED_STATS_EN
  logic [31:0] lookups_q, updates_q, mispreds_q;

  assign stat_lookups  = lookups_q;
  assign stat_updates  = updates_q;
  assign stat_mispreds = mispreds_q;

  // Event counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookups_q  <= '0;
      updates_q  <= '0;
      mispreds_q <= '0;
    end else begin
      if (ready_q && pred_req && pred_br)        lookups_q  <= lookups_q + 32'd1;
      if (ready_q && upd_valid)                  updates_q  <= updates_q + 32'd1;
      if (ready_q && upd_valid && upd_mispred)   mispreds_q <= mispreds_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gshare_pred_unit.sv
// Randomized bench for gshare_pred_unit against a table-level reference model.
module tb_gshare_pred_unit;

  localparam int unsigned GHR_W = 8;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned CNT_W = 2;
  localparam int          N     = 1 << IDX_W;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam int          HALF  = 1 << (CNT_W - 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic             pred_req, pred_br;
  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid, upd_taken, upd_mispred;
  logic [IDX_W-1:0] upd_idx;
  logic [GHR_W-1:0] upd_ghr;
`ifdef GSHARE_PRED_STATS_EN
  logic [31:0]      stat_lookups, stat_updates, stat_mispreds;
`endif

  gshare_pred_unit #(
    .GHR_W     (GHR_W),
    .PHT_IDX_W (IDX_W),
    .CNT_W     (CNT_W),
    .HASH_MODE (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .pred_req    (pred_req),
    .pred_br     (pred_br),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_idx    (pred_idx),
    .pred_ghr    (pred_ghr),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_taken   (upd_taken),
    .upd_mispred (upd_mispred),
    .upd_ghr     (upd_ghr)
`ifdef GSHARE_PRED_STATS_EN
    ,
    .stat_lookups  (stat_lookups),
    .stat_updates  (stat_updates),
    .stat_mispreds (stat_mispreds)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: counter table, history, cycles since reset release.
  int          m_pht [N];
  int          m_ghr;
  int          m_since;
  bit          m_started;
  int unsigned m_lk, m_up, m_mp;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pc_for(input int idx);
    return 32'(((idx ^ m_ghr) & (N - 1)) << 2);
  endfunction

  task automatic idle_inputs();
    pred_req = 0; pred_br = 0; pred_pc = '0;
    upd_valid = 0; upd_idx = '0; upd_taken = 0; upd_mispred = 0; upd_ghr = '0;
  endtask

  task automatic rand_inputs();
    pred_req    = 1'($urandom_range(0, 1));
    pred_br     = 1'($urandom_range(0, 1));
    pred_pc     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31) << 2);
    upd_valid   = 1'($urandom_range(0, 1));
    upd_idx     = IDX_W'($urandom_range(0, 15));
    upd_taken   = 1'($urandom_range(0, 1));
    upd_mispred = ($urandom_range(0, 3) == 0);
    upd_ghr     = GHR_W'($urandom);
  endtask

  // Compare outputs for the driven inputs, then advance model and clock together.
  task automatic step();
    int idx, c;
    bit rdy, pt;
    #2;
    idx = ((int'(pred_pc) >>> 2) & (N - 1)) ^ m_ghr;
    rdy = (m_since >= N);
    pt  = rdy && (m_pht[idx] >= HALF);
    if (m_started) begin
      chk("ready", 32'(ready), 32'(rdy));
      chk("pred_idx", 32'(pred_idx), 32'(idx));
      chk("pred_ghr", 32'(pred_ghr), 32'(m_ghr));
      chk("pred_taken", 32'(pred_taken), 32'(pt));
    end
    if (rst) begin
      m_started = 1; m_since = 0; m_ghr = 0;
      m_lk = 0; m_up = 0; m_mp = 0;
      for (int i = 0; i < N; i++) m_pht[i] = HALF - 1;
    end else if (!rdy) begin
      m_since++;
    end else begin
      if (upd_valid) begin
        c = m_pht[upd_idx];
        m_pht[upd_idx] = upd_taken ? ((c == CMAX) ? c : c + 1) : ((c == 0) ? 0 : c - 1);
        m_up++;
        if (upd_mispred) m_mp++;
      end
      if (pred_req && pred_br) m_lk++;
      if (upd_valid && upd_mispred)
        m_ghr = ((int'(upd_ghr) << 1) | int'(upd_taken)) & ((1 << GHR_W) - 1);
      else if (pred_req && pred_br)
        m_ghr = ((m_ghr << 1) | int'(pt)) & ((1 << GHR_W) - 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_sweep();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < N; i++) step();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;

    // Requests and updates during the sweep are ignored; reset mid-sweep restarts it.
    for (int i = 0; i < 7; i++) begin rand_inputs(); step(); end
    idle_inputs(); rst = 1; step(); rst = 0;
    for (int i = 0; i < N + 8; i++) begin rand_inputs(); step(); end

    reset_and_sweep();

    // Saturation on entry 5: up three times, down four times.
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      pred_req = 1; pred_pc = pc_for(5);
      upd_valid = 1; upd_idx = 5; upd_taken = (i < 3);
      step();
    end
    idle_inputs(); pred_req = 1; pred_pc = pc_for(5);
    #2; chk("sat_floor_taken", 32'(pred_taken), 32'd0);
    step();

    // Hash: load history A5 through a repair, then look up pc 0x40.
    idle_inputs(); upd_valid = 1; upd_mispred = 1; upd_ghr = 8'h52; upd_taken = 1; upd_idx = 0;
    step();
    idle_inputs(); pred_req = 1; pred_pc = 32'h0000_0040;
    #2; chk("hash_idx", 32'(pred_idx), 32'h0B5);
    step();

    // Speculative shift: history 01, entry predicts taken -> 03; no shift without pred_br.
    idle_inputs(); upd_valid = 1; upd_mispred = 1; upd_ghr = 8'h00; upd_taken = 1; upd_idx = 9;
    step();
    idle_inputs(); upd_valid = 1; upd_idx = 9; upd_taken = 1;
    step();
    idle_inputs(); pred_req = 1; pred_br = 1; pred_pc = pc_for(9);
    step();
    idle_inputs(); pred_req = 1; pred_pc = pc_for(9);
    #2; chk("spec_shift", 32'(pred_ghr), 32'h03);
    step();
    idle_inputs();
    #2; chk("no_shift", 32'(pred_ghr), 32'h03);

    // Repair beats a same-cycle speculative shift.
    pred_req = 1; pred_br = 1; pred_pc = pc_for(9);
    upd_valid = 1; upd_mispred = 1; upd_ghr = 8'h80; upd_taken = 0; upd_idx = 9;
    step();
    idle_inputs();
    #2; chk("repair_prio", 32'(pred_ghr), 32'h00);
    step();

    // Same-index update and lookup: no bypass.
    idle_inputs(); pred_req = 1; pred_pc = pc_for(3);
    upd_valid = 1; upd_idx = 3; upd_taken = 1;
    #2; chk("collide_old", 32'(pred_taken), 32'd0);
    step();
    idle_inputs(); pred_req = 1; pred_pc = pc_for(3);
    #2; chk("collide_new", 32'(pred_taken), 32'd1);
    step();

    // Random traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rst = (i == 1500);
      step();
    end
    rst = 0;

`ifdef GSHARE_PRED_STATS_EN
    idle_inputs();
    #2;
    chk("stat_lookups", stat_lookups, m_lk);
    chk("stat_updates", stat_updates, m_up);
    chk("stat_mispreds", stat_mispreds, m_mp);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gshare_pred_unit.md
Name: gshare_pred_unit

Overview:
- Parametrised global-history branch predictor for the 5-stage MIPS pipeline.
- Sits beside the PC/fetch logic. Fetch queries it each cycle; the branch-resolution stage writes back outcomes.
- Generalises the fixed global predictor:
  - configurable history length and PHT depth;
  - selectable index hash (gshare XOR or pure global);
  - parametrised counter width;
  - speculative history with mispredict repair;
  - self-initialising PHT.

Parameters:
- GHR_W, 8, global history register width in bits (1..PHT_IDX_W).
- PHT_IDX_W, 10, log2 of PHT entries (1024 by default).
- CNT_W, 2, saturating counter width (2..4).
- HASH_MODE, 0, index hash: 0 = gshare (pc[PHT_IDX_W+1:2] XOR zero-extended GHR), 1 = global (zero-extended GHR only).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high once the PHT init sweep is done.
- pred_req  in  1  fetch lookup valid this cycle.
- pred_br  in  1  fetched instruction is a conditional branch (shifts the speculative GHR).
- pred_pc  in  32  fetch PC.
- pred_taken  out  1  predicted direction (combinational from PHT and GHR).
- pred_idx  out  PHT_IDX_W  PHT index used; carried down the pipeline.
- pred_ghr  out  GHR_W  GHR snapshot before this prediction; carried down the pipeline.
- upd_valid  in  1  resolved conditional branch.
- upd_idx  in  PHT_IDX_W  index captured at predict time.
- upd_taken  in  1  actual outcome.
- upd_mispred  in  1  direction was mispredicted; repair the GHR.
- upd_ghr  in  GHR_W  snapshot captured at predict time.

Behaviour:
- FSM states:
  - INIT: walk init_ptr from 0 to 2^PHT_IDX_W-1. Write one entry per cycle with weakly-not-taken (2^(CNT_W-1)-1, i.e. 01 for CNT_W=2).
  - RUN: entered the cycle after the last entry is written.
- Timing: ready rises exactly 2^PHT_IDX_W cycles after rst deasserts.
- Reset values: state INIT, init_ptr 0, ghr 0, ready 0.
- Reset at any point, including mid-sweep, restarts INIT from entry 0.
- pred_taken: MSB of PHT[idx] when ready, else 0.
  - pred_idx and pred_ghr are valid whenever pred_req is high.
  - All requests and updates in INIT are ignored, with no state change.
- Speculative GHR: when ready && pred_req && pred_br, ghr <= {ghr[GHR_W-2:0], pred_taken} on the next edge.
- Counter update: when ready && upd_valid, PHT[upd_idx] saturates upward if upd_taken, else downward.
  - Ceiling is 2^CNT_W-1; floor is 0. No wrap at either end.
- Repair: when ready && upd_valid && upd_mispred, ghr <= {upd_ghr[GHR_W-2:0], upd_taken}.
  - Repair has priority over a same-cycle speculative shift; that shift is discarded, because the fetch is on the wrong path.
- Same-cycle update and lookup on one index: the lookup sees the pre-update value. No bypass.
- Latency:
  - prediction: 0 cycles (combinational);
  - update visible to lookups: 1 cycle;
  - GHR change visible: 1 cycle.
- upd_mispred without upd_valid is ignored.

Optional Feature:
- Macro: GSHARE_PRED_STATS_EN.
- When defined, the block adds three outputs:
  - stat_lookups: 32-bit count of ready && pred_req && pred_br;
  - stat_updates: 32-bit count of ready && upd_valid;
  - stat_mispreds: 32-bit count of ready && upd_valid && upd_mispred.
- All three reset to 0 and wrap modulo 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package gshare_pred_pkg holds:
  - FSM state enum (ST_INIT, ST_RUN);
  - HASH_GSHARE=0 and HASH_GLOBAL=1;
  - function cnt_sat_next(cnt, taken, CNT_W).
- One natural sub-module, pht_ram:
  - 2^PHT_IDX_W x CNT_W;
  - one combinational read port and one synchronous write port;
  - the write port is muxed between the init sweep and the counter update.

Test Plan:
- Init timing (PHT_IDX_W=4): deassert rst → ready goes high at cycle 16. Before that, pred_taken=0 and a stimulus upd_valid leaves the entry at 01. Pulse rst at cycle 7 → ready goes high 16 cycles after the second deassert.
- Saturation (CNT_W=2, idx 5): three taken updates → counter 01→10→11→11 and pred_taken=1. Then four not-taken updates → 11→10→01→00→00 and pred_taken=0.
- Hash: HASH_MODE=0, GHR=8'hA5, pc=32'h0000_0040 → pred_idx = 10'h010 ^ 10'h0A5 = 10'h0B5. With HASH_MODE=1 → 10'h0A5.
- Speculative shift: GHR=8'h01 and PHT[idx] MSB=1, pred_req=pred_br=1 → GHR=8'h03 next cycle. With pred_br=0 → unchanged.
- Repair priority: same cycle pred_br=1 (predict 1) and upd_mispred=1, upd_ghr=8'h80, upd_taken=0 → GHR=8'h00, not a shifted speculative value.
- Same-index collision: PHT[3]=01, same cycle lookup idx 3 and taken update idx 3 → pred_taken=0 this cycle. Next cycle's lookup → 1.
